// File: rtl/ctrl_window_checker.sv
// rtl/ctrl_window_checker.sv - trigger-implies-response window checker
//
// Purpose:
//   Run-time checker for rules of the form "trigger on channel c implies
//   ctrl_bus matches (exp_val_c under exp_mask_c) within [MIN_DLY:MAX_DLY]
//   cycles". NUM_CH independent channels share one monitored control bus.
//   Every trigger is tracked separately by age, so back-to-back triggers
//   are never lost and one match may satisfy several overlapping triggers.
//   Violations and satisfied triggers are counted (saturating) so the
//   checker is useful in FPGA/emulation as well as in simulation.
//
// Ports:
//   clk         core clock
//   rst_n       asynchronous active-low reset
//   en          checker enable; low flushes history and ignores triggers
//   clr         synchronous clear of counters and sticky flags
//   trig_vec    per-channel trigger, sampled on rising clk
//   ctrl_bus    monitored control signals
//   exp_mask    per-channel care mask, channel c at [c*SIG_WIDTH +: SIG_WIDTH]
//   exp_val     per-channel expected value, same slicing as exp_mask
//   err_pulse   one-cycle violation strobe per channel
//   err_sticky  latched violation flag per channel
//   viol_cnt    per-channel saturating violation count
//   pass_cnt    per-channel saturating satisfied-trigger count
//   busy        registered OR of all pending triggers
//
// Optional build macro CHK_FIRST_ERR_CAPTURE_EN adds:
//   first_err_valid  a first violation has been captured
//   first_err_ch     lowest-numbered channel violating on that cycle
//   first_err_time   free-running cycle counter value at the err_pulse cycle

module ctrl_window_checker #(
  parameter int NUM_CH    = 4,
  parameter int SIG_WIDTH = 16,
  parameter int MIN_DLY   = 1,
  parameter int MAX_DLY   = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          clr,
  input  logic [NUM_CH-1:0]             trig_vec,
  input  logic [SIG_WIDTH-1:0]          ctrl_bus,
  input  logic [NUM_CH*SIG_WIDTH-1:0]   exp_mask,
  input  logic [NUM_CH*SIG_WIDTH-1:0]   exp_val,
  output logic [NUM_CH-1:0]             err_pulse,
  output logic [NUM_CH-1:0]             err_sticky,
  output logic [NUM_CH*CNT_WIDTH-1:0]   viol_cnt,
  output logic [NUM_CH*CNT_WIDTH-1:0]   pass_cnt,
  output logic                          busy
`ifdef CHK_FIRST_ERR_CAPTURE_EN
  ,
  output logic                                    first_err_valid,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_err_ch,
  output logic [31:0]                             first_err_time
`endif
);

  // Stored ages are 0..MAX_DLY-1: a trigger reaching age MAX_DLY is always
  // resolved (passed or dropped) on that edge, so it is never stored.
  localparam int PW = (MAX_DLY > 0) ? MAX_DLY : 1;

  logic [PW-1:0]        pend    [NUM_CH];
  logic [PW-1:0]        ch_next [NUM_CH];
  logic [4:0]           ch_inc  [NUM_CH];
  logic [NUM_CH-1:0]    ch_viol;
  logic [CNT_WIDTH-1:0] vcnt    [NUM_CH];
  logic [CNT_WIDTH-1:0] pcnt    [NUM_CH];
  logic                 any_next;

  // Saturating add; the increment is at most MAX_DLY-MIN_DLY+1 <= 16.
  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] base,
    input logic [4:0]           inc
  );
    logic [CNT_WIDTH+4:0] sum;
    sum = {5'b0, base} + {{CNT_WIDTH{1'b0}}, inc};
    if (sum[CNT_WIDTH+4:CNT_WIDTH] != 5'b0) begin
      sat_add = '1;
    end else begin
      sat_add = sum[CNT_WIDTH-1:0];
    end
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [MAX_DLY:0] age_v;
    logic [MAX_DLY:0] sat_v;
    logic [MAX_DLY:0] rem_v;
    logic [PW-1:0]    nxt_l;
    logic [4:0]       inc_l;
    logic             viol_l;
    logic             match_l;

    always_comb begin
      match_l = (((ctrl_bus ^ exp_val[g*SIG_WIDTH +: SIG_WIDTH])
                  & exp_mask[g*SIG_WIDTH +: SIG_WIDTH]) == '0);

      // Ages as seen at this edge: the new trigger is age 0, everything
      // stored moves up by one.
      age_v    = '0;
      age_v[0] = trig_vec[g];
      for (int k = 1; k <= MAX_DLY; k++) begin
        age_v[k] = pend[g][k-1];
      end

      // A match retires every outstanding trigger inside the window.
      sat_v = '0;
      for (int k = MIN_DLY; k <= MAX_DLY; k++) begin
        sat_v[k] = age_v[k] & match_l;
      end
      rem_v = age_v & ~sat_v;

      inc_l = '0;
      for (int k = 0; k <= MAX_DLY; k++) begin
        inc_l = inc_l + {4'b0, sat_v[k]};
      end

      viol_l = rem_v[MAX_DLY];
      nxt_l  = '0;
      for (int k = 0; k < MAX_DLY; k++) begin
        nxt_l[k] = rem_v[k];
      end

      // Disabled: drop all history silently and ignore the bus.
      if (!en) begin
        nxt_l  = '0;
        viol_l = 1'b0;
        inc_l  = '0;
      end
    end

    assign ch_next[g] = nxt_l;
    assign ch_inc[g]  = inc_l;
    assign ch_viol[g] = viol_l;

    assign viol_cnt[g*CNT_WIDTH +: CNT_WIDTH] = vcnt[g];
    assign pass_cnt[g*CNT_WIDTH +: CNT_WIDTH] = pcnt[g];
  end

  always_comb begin
    any_next = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      any_next = any_next | (|ch_next[c]);
    end
  end

  // clr zeroes the base value; events resolved on the same edge are then
  // added on top, so a violation coincident with clr leaves a count of 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        pend[c] <= '0;
        vcnt[c] <= '0;
        pcnt[c] <= '0;
      end
      err_pulse  <= '0;
      err_sticky <= '0;
      busy       <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        pend[c]       <= ch_next[c];
        err_pulse[c]  <= ch_viol[c];
        err_sticky[c] <= (err_sticky[c] & ~clr) | ch_viol[c];
        vcnt[c]       <= sat_add(clr ? '0 : vcnt[c], {4'b0, ch_viol[c]});
        pcnt[c]       <= sat_add(clr ? '0 : pcnt[c], ch_inc[c]);
      end
      busy <= any_next;
    end
  end

`ifdef CHK_FIRST_ERR_CAPTURE_EN
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [31:0]    cyc_cnt;
  logic [CHW-1:0] low_ch;

  always_comb begin
    low_ch = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (ch_viol[c]) begin
        low_ch = CHW'(c);
      end
    end
  end

  // The captured time is the counter value visible during the err_pulse
  // cycle, i.e. the value the counter takes on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_ch    <= '0;
      first_err_time  <= '0;
    end else begin
      if (en) begin
        cyc_cnt <= cyc_cnt + 32'd1;
      end
      if (clr) begin
        first_err_valid <= 1'b0;
        first_err_ch    <= '0;
        first_err_time  <= '0;
      end
      if ((clr || !first_err_valid) && (|ch_viol)) begin
        first_err_valid <= 1'b1;
        first_err_ch    <= low_ch;
        first_err_time  <= cyc_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_window_checker.sv
// tb/tb_ctrl_window_checker.sv - self-checking bench for ctrl_window_checker
//
// Two instances share all inputs: dut_a with default parameters and dut_b
// with MIN_DLY=0, MAX_DLY=3, CNT_WIDTH=4. The reference model keeps a queue
// of trigger timestamps per channel and resolves them by age arithmetic.

module tb_ctrl_window_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  trig_vec = '0;
  logic [15:0] ctrl_bus = '0;
  logic [63:0] exp_mask = '0;
  logic [63:0] exp_val = '0;

  logic [3:0]  a_err_pulse, a_err_sticky, b_err_pulse, b_err_sticky;
  logic [63:0] a_viol_cnt, a_pass_cnt;
  logic [15:0] b_viol_cnt, b_pass_cnt;
  logic        a_busy, b_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ctrl_window_checker dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .trig_vec(trig_vec),
    .ctrl_bus(ctrl_bus), .exp_mask(exp_mask), .exp_val(exp_val),
    .err_pulse(a_err_pulse), .err_sticky(a_err_sticky),
    .viol_cnt(a_viol_cnt), .pass_cnt(a_pass_cnt), .busy(a_busy)
  );

  ctrl_window_checker #(
    .NUM_CH(4), .SIG_WIDTH(16), .MIN_DLY(0), .MAX_DLY(3), .CNT_WIDTH(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .trig_vec(trig_vec),
    .ctrl_bus(ctrl_bus), .exp_mask(exp_mask), .exp_val(exp_val),
    .err_pulse(b_err_pulse), .err_sticky(b_err_sticky),
    .viol_cnt(b_viol_cnt), .pass_cnt(b_pass_cnt), .busy(b_busy)
  );

  // Reference model: index d*4+c, d=0 for dut_a, d=1 for dut_b.
  int pq [8][$];
  int mv [8];
  int mp [8];
  bit mpulse [8];
  bit mstick [8];
  bit mbusy [2];
  int ecyc = 0;
  int mn [2] = '{1, 0};
  int mx [2] = '{2, 3};
  int cmax [2] = '{65535, 15};

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      pq[i].delete();
      mv[i] = 0;
      mp[i] = 0;
      mpulse[i] = 0;
      mstick[i] = 0;
    end
    mbusy[0] = 0;
    mbusy[1] = 0;
  endtask

  task automatic model_tick();
    for (int d = 0; d < 2; d++) begin
      mbusy[d] = 0;
      for (int c = 0; c < 4; c++) begin
        int idx;
        int nv;
        int np;
        int age;
        bit m;
        int keep [$];
        idx = d * 4 + c;
        nv = 0;
        np = 0;
        keep.delete();
        if (!en) begin
          pq[idx].delete();
        end else begin
          if (trig_vec[c]) pq[idx].push_back(ecyc);
          m = ((ctrl_bus ^ exp_val[c*16 +: 16]) & exp_mask[c*16 +: 16]) == 16'h0;
          for (int j = 0; j < pq[idx].size(); j++) begin
            age = ecyc - pq[idx][j];
            if (m && age >= mn[d] && age <= mx[d]) np++;
            else if (age >= mx[d]) nv++;
            else keep.push_back(pq[idx][j]);
          end
          pq[idx] = keep;
        end
        if (clr) begin
          mv[idx] = 0;
          mp[idx] = 0;
          mstick[idx] = 0;
        end
        mv[idx] = (mv[idx] + nv > cmax[d]) ? cmax[d] : mv[idx] + nv;
        mp[idx] = (mp[idx] + np > cmax[d]) ? cmax[d] : mp[idx] + np;
        mpulse[idx] = (nv > 0);
        if (nv > 0) mstick[idx] = 1;
        if (pq[idx].size() > 0) mbusy[d] = 1;
      end
    end
    ecyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_tick();
    else model_reset();
    #1;
  endtask

  task automatic settle();
    trig_vec = '0;
    ctrl_bus = '0;
    clr = 1'b0;
    en = 1'b1;
    repeat (5) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    repeat (2) tick();
    if (a_err_pulse !== 4'h0) begin n_errors++; $display("FAIL reset_pulse got %h exp 0", a_err_pulse); end
    n_checks++;
    if (a_err_sticky !== 4'h0) begin n_errors++; $display("FAIL reset_sticky got %h exp 0", a_err_sticky); end
    n_checks++;
    if (a_viol_cnt !== 64'h0) begin n_errors++; $display("FAIL reset_viol got %h exp 0", a_viol_cnt); end
    n_checks++;
    if (a_pass_cnt !== 64'h0) begin n_errors++; $display("FAIL reset_pass got %h exp 0", a_pass_cnt); end
    n_checks++;
    if ({a_busy, b_busy} !== 2'b00) begin n_errors++; $display("FAIL reset_busy got %b exp 00", {a_busy, b_busy}); end
    n_checks++;
    rst_n = 1'b1;
  endtask

  task automatic test_pass();
    settle();
    exp_mask[15:0] = 16'h0003;
    exp_val[15:0] = 16'h0003;
    trig_vec = 4'b0001;
    tick();
    trig_vec = '0;
    if (a_busy !== 1'b1) begin n_errors++; $display("FAIL pass_busy_set got %b exp 1", a_busy); end
    n_checks++;
    tick();
    ctrl_bus = 16'h0003;
    tick();
    ctrl_bus = '0;
    if (a_err_pulse !== 4'h0) begin n_errors++; $display("FAIL pass_pulse got %h exp 0", a_err_pulse); end
    n_checks++;
    if (a_pass_cnt[15:0] !== 16'd1) begin n_errors++; $display("FAIL pass_cnt got %0d exp 1", a_pass_cnt[15:0]); end
    n_checks++;
    if (a_busy !== 1'b0) begin n_errors++; $display("FAIL pass_busy_clr got %b exp 0", a_busy); end
    n_checks++;
  endtask

  task automatic test_violation();
    settle();
    trig_vec = 4'b0001;
    tick();
    trig_vec = '0;
    tick();
    if (a_err_pulse !== 4'h0) begin n_errors++; $display("FAIL viol_early got %h exp 0", a_err_pulse); end
    n_checks++;
    tick();
    if (a_err_pulse !== 4'b0001) begin n_errors++; $display("FAIL viol_pulse got %h exp 1", a_err_pulse); end
    n_checks++;
    if (a_err_sticky[0] !== 1'b1) begin n_errors++; $display("FAIL viol_sticky got %b exp 1", a_err_sticky[0]); end
    n_checks++;
    if (a_viol_cnt[15:0] !== 16'd1) begin n_errors++; $display("FAIL viol_cnt got %0d exp 1", a_viol_cnt[15:0]); end
    n_checks++;
    tick();
    if (a_err_pulse !== 4'h0) begin n_errors++; $display("FAIL viol_one_cycle got %h exp 0", a_err_pulse); end
    n_checks++;
  endtask

  task automatic test_min_zero();
    settle();
    trig_vec = 4'b0001;
    ctrl_bus = 16'h0003;
    tick();
    trig_vec = '0;
    ctrl_bus = '0;
    if (b_pass_cnt[3:0] !== 4'd1) begin n_errors++; $display("FAIL min0_pass got %0d exp 1", b_pass_cnt[3:0]); end
    n_checks++;
    if (b_busy !== 1'b0) begin n_errors++; $display("FAIL min0_busy got %b exp 0", b_busy); end
    n_checks++;
    settle();
    trig_vec = 4'b0001;
    tick();
    trig_vec = '0;
    repeat (2) tick();
    if (b_err_pulse !== 4'h0) begin n_errors++; $display("FAIL min0_early got %h exp 0", b_err_pulse); end
    n_checks++;
    tick();
    if (b_err_pulse !== 4'b0001 || b_viol_cnt[3:0] !== 4'd1) begin
      n_errors++;
      $display("FAIL min0_late_viol got pulse %h cnt %0d exp 1 1", b_err_pulse, b_viol_cnt[3:0]);
    end
    n_checks++;
    ctrl_bus = 16'h0003;
    tick();
    ctrl_bus = '0;
    if (b_pass_cnt[3:0] !== 4'd0) begin n_errors++; $display("FAIL min0_late_pass got %0d exp 0", b_pass_cnt[3:0]); end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    settle();
    exp_mask[31:16] = 16'h00F0;
    exp_val[31:16] = 16'h0050;
    trig_vec = 4'b0010;
    repeat (2) tick();
    ctrl_bus = 16'h0050;
    tick();
    trig_vec = '0;
    ctrl_bus = '0;
    if (a_pass_cnt[31:16] !== 16'd2) begin n_errors++; $display("FAIL b2b_pass got %0d exp 2", a_pass_cnt[31:16]); end
    n_checks++;
    if (a_busy !== 1'b1) begin n_errors++; $display("FAIL b2b_busy got %b exp 1", a_busy); end
    n_checks++;
    tick();
    if (a_err_pulse !== 4'h0) begin n_errors++; $display("FAIL b2b_early got %h exp 0", a_err_pulse); end
    n_checks++;
    tick();
    if (a_err_pulse !== 4'b0010 || a_viol_cnt[31:16] !== 16'd1) begin
      n_errors++;
      $display("FAIL b2b_viol got pulse %h cnt %0d exp 2 1", a_err_pulse, a_viol_cnt[31:16]);
    end
    n_checks++;
  endtask

  task automatic test_saturation();
    settle();
    exp_mask[63:48] = 16'hFFFF;
    exp_val[63:48] = 16'hFFFF;
    trig_vec = 4'b1000;
    repeat (20) tick();
    trig_vec = '0;
    repeat (5) tick();
    if (b_viol_cnt[15:12] !== 4'd15) begin n_errors++; $display("FAIL sat_b got %0d exp 15", b_viol_cnt[15:12]); end
    n_checks++;
    if (a_viol_cnt[63:48] !== 16'd20) begin n_errors++; $display("FAIL sat_a got %0d exp 20", a_viol_cnt[63:48]); end
    n_checks++;
    trig_vec = 4'b1000;
    tick();
    trig_vec = '0;
    repeat (2) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    if (b_viol_cnt[15:12] !== 4'd1 || b_err_sticky[3] !== 1'b1) begin
      n_errors++;
      $display("FAIL clr_coincident got cnt %0d sticky %b exp 1 1", b_viol_cnt[15:12], b_err_sticky[3]);
    end
    n_checks++;
    if (a_viol_cnt[63:48] !== 16'd0 || a_err_sticky[3] !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_plain got cnt %0d sticky %b exp 0 0", a_viol_cnt[63:48], a_err_sticky[3]);
    end
    n_checks++;
  endtask

  task automatic test_en_low();
    logic [3:0] seen;
    settle();
    trig_vec = 4'b0001;
    tick();
    trig_vec = '0;
    repeat (4) tick();
    trig_vec = 4'b0001;
    repeat (2) tick();
    trig_vec = '0;
    en = 1'b0;
    tick();
    if (a_err_pulse !== 4'h0 || {a_busy, b_busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL en_flush got pulse %h busy %b%b exp 0 00", a_err_pulse, a_busy, b_busy);
    end
    n_checks++;
    if (a_viol_cnt[15:0] !== 16'd1 || a_err_sticky[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL en_hold got cnt %0d sticky %b exp 1 1", a_viol_cnt[15:0], a_err_sticky[0]);
    end
    n_checks++;
    trig_vec = 4'b0001;
    repeat (2) tick();
    trig_vec = '0;
    en = 1'b1;
    seen = '0;
    repeat (6) begin
      tick();
      seen = seen | a_err_pulse | b_err_pulse;
    end
    if (seen !== 4'h0 || a_viol_cnt[15:0] !== 16'd1) begin
      n_errors++;
      $display("FAIL en_ignore got pulses %h cnt %0d exp 0 1", seen, a_viol_cnt[15:0]);
    end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] seen;
    settle();
    trig_vec = 4'b0001;
    tick();
    trig_vec = '0;
    tick();
    rst_n = 1'b0;
    #1;
    if (a_busy !== 1'b0 || a_viol_cnt !== 64'h0 || a_err_sticky !== 4'h0) begin
      n_errors++;
      $display("FAIL rst_async got busy %b sticky %h exp 0 0", a_busy, a_err_sticky);
    end
    n_checks++;
    tick();
    rst_n = 1'b1;
    seen = '0;
    repeat (5) begin
      tick();
      seen = seen | a_err_pulse | b_err_pulse;
    end
    if (seen !== 4'h0 || a_viol_cnt !== 64'h0) begin
      n_errors++;
      $display("FAIL rst_mid got pulses %h exp 0", seen);
    end
    n_checks++;
  endtask

  task automatic test_random();
    logic [3:0]  ea_pulse, ea_st, eb_pulse, eb_st;
    logic [63:0] ea_v, ea_p;
    logic [15:0] eb_v, eb_p;
    for (int it = 0; it < 3000; it++) begin
      if (it % 250 == 0) begin
        for (int c = 0; c < 4; c++) begin
          if ($urandom_range(0, 9) == 0) exp_mask[c*16 +: 16] = 16'h0;
          else exp_mask[c*16 +: 16] = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
          exp_val[c*16 +: 16] = 16'($urandom);
        end
      end
      en = ($urandom_range(0, 19) != 0);
      clr = ($urandom_range(0, 39) == 0);
      trig_vec = 4'($urandom);
      ctrl_bus = 16'($urandom);
      tick();
      for (int c = 0; c < 4; c++) begin
        ea_pulse[c] = mpulse[c];
        ea_st[c] = mstick[c];
        eb_pulse[c] = mpulse[4+c];
        eb_st[c] = mstick[4+c];
        ea_v[c*16 +: 16] = 16'(mv[c]);
        ea_p[c*16 +: 16] = 16'(mp[c]);
        eb_v[c*4 +: 4] = 4'(mv[4+c]);
        eb_p[c*4 +: 4] = 4'(mp[4+c]);
      end
      if (a_err_pulse !== ea_pulse || b_err_pulse !== eb_pulse) begin
        n_errors++;
        $display("FAIL rnd_pulse it %0d got %h %h exp %h %h", it, a_err_pulse, b_err_pulse, ea_pulse, eb_pulse);
      end
      n_checks++;
      if (a_err_sticky !== ea_st || b_err_sticky !== eb_st) begin
        n_errors++;
        $display("FAIL rnd_sticky it %0d got %h %h exp %h %h", it, a_err_sticky, b_err_sticky, ea_st, eb_st);
      end
      n_checks++;
      if (a_viol_cnt !== ea_v || b_viol_cnt !== eb_v) begin
        n_errors++;
        $display("FAIL rnd_viol it %0d got %h %h exp %h %h", it, a_viol_cnt, b_viol_cnt, ea_v, eb_v);
      end
      n_checks++;
      if (a_pass_cnt !== ea_p || b_pass_cnt !== eb_p) begin
        n_errors++;
        $display("FAIL rnd_pass it %0d got %h %h exp %h %h", it, a_pass_cnt, b_pass_cnt, ea_p, eb_p);
      end
      n_checks++;
      if (a_busy !== mbusy[0] || b_busy !== mbusy[1]) begin
        n_errors++;
        $display("FAIL rnd_busy it %0d got %b %b exp %b %b", it, a_busy, b_busy, mbusy[0], mbusy[1]);
      end
      n_checks++;
    end
    clr = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pass();
    test_violation();
    test_min_zero();
    test_back_to_back();
    test_saturation();
    test_en_low();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
